fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decode stage. It holds the program counter, issues word reads to instruction memory over a req/ack + rvalid handshake, buffers returned words with their PCs in a small prefetch queue, and presents one instruction per cycle to decode. Taken branches from downstream redirect the PC, flush the queue and discard any in-flight response.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding imem reads,
// small prefetch queue and registered one-instruction-per-cycle output to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_pc,
   input  logic [31:0] branch_offset,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef enum logic [1:0] {
      ISSUE     = 2'd0,
      WAIT_RESP = 2'd1,
      WAIT_DROP = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [31:0]      q_instr [DEPTH];
   logic [31:0]      q_pc    [DEPTH];
   logic [PTR_W-1:0] rd_ptr, rd_ptr_d, wr_ptr, wr_ptr_d;
   logic [CNT_W-1:0] count, count_d;
   logic [31:0]      fetch_pc_d, instruction_d, instr_pc_d;
   logic [31:0]      target_sum, target, push_pc;
   logic             imem_req_d, instr_valid_d;
   logic             accepted, push, pop;

   // imem_addr doubles as the fetch PC; it only advances on acceptance,
   // so while waiting for a response the outstanding PC is imem_addr - 4.
   always_comb begin
      state_d       = state;
      fetch_pc_d    = imem_addr;
      rd_ptr_d      = rd_ptr;
      wr_ptr_d      = wr_ptr;
      count_d       = count;
      push          = 1'b0;
      pop           = 1'b0;
      imem_req_d    = 1'b0;
      instr_valid_d = 1'b0;
      instruction_d = NOP;
      instr_pc_d    = instr_pc;
      accepted      = imem_req && imem_ack;
      target_sum    = branch_pc + branch_offset;
      target        = {target_sum[31:2], 2'b00};
      push_pc       = imem_addr - 32'd4;

      case (state)
         ISSUE: begin
            if (accepted) begin
               state_d    = branch_taken ? WAIT_DROP : WAIT_RESP;
               fetch_pc_d = imem_addr + 32'd4;
            end
         end
         WAIT_RESP: begin
            if (imem_rvalid) begin
               state_d = ISSUE;
               push    = !branch_taken;
            end else if (branch_taken) begin
               state_d = WAIT_DROP;
            end
         end
         WAIT_DROP: begin
            if (imem_rvalid) state_d = ISSUE;
         end
         default: state_d = ISSUE;
      endcase

      pop = instr_valid && !stall && !branch_taken;

      // Redirect empties the queue and retargets fetch, overriding push/pop
      if (branch_taken) begin
         fetch_pc_d = target;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
         endcase
      end

      imem_req_d    = (state_d == ISSUE) && (count_d < CNT_W'(DEPTH));
      instr_valid_d = (count_d != '0);

      // Next head is the word being pushed when it lands in the head slot
      if (count_d != '0) begin
         if (push && (wr_ptr == rd_ptr_d)) begin
            instruction_d = imem_rdata;
            instr_pc_d    = push_pc;
         end else begin
            instruction_d = q_instr[rd_ptr_d];
            instr_pc_d    = q_pc[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ISSUE;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         instr_valid <= 1'b0;
         instruction <= NOP;
         instr_pc    <= 32'h0000_0000;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_instr[i] <= 32'h0000_0000;
            q_pc[i]    <= 32'h0000_0000;
         end
      end else begin
         state       <= state_d;
         imem_req    <= imem_req_d;
         imem_addr   <= fetch_pc_d;
         rd_ptr      <= rd_ptr_d;
         wr_ptr      <= wr_ptr_d;
         count       <= count_d;
         instr_valid <= instr_valid_d;
         instruction <= instruction_d;
         instr_pc    <= instr_pc_d;
         if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= push_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory, per-cycle vector table
// for the reset-release sequence, and a PC scoreboard for everything delivered.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_pc;
   logic [31:0] branch_offset;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] instr_pc;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .branch_taken(branch_taken),
      .branch_pc(branch_pc), .branch_offset(branch_offset),
      .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          ack_delay = 0;
   int          lat = 1;
   int          ack_wait = 0;
   int          due = 0;
   int          inject = 0;
   bit          mem_out = 0;
   bit          ack_seen = 0;
   bit          prev_hold = 0;
   bit          prev_branch = 0;
   logic [31:0] prev_addr = '0;
   logic [31:0] resp_addr = '0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_q[$];
   logic [31:0] got_pcs[$];

   typedef struct {
      logic        stall;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic bench_clear();
      mem_out     = 0;
      ack_wait    = 0;
      prev_hold   = 0;
      prev_branch = 0;
      exp_q.delete();
      exp_pc      = RESET_PC;
      got_pcs.delete();
      cyc         = 0;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      stall        = 1'b0;
      branch_taken = 1'b0;
      imem_ack     = 1'b0;
      imem_rvalid  = 1'b0;
      bench_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   // One clock period: called at a falling edge with stall/branch already set.
   task automatic cycle();
      if (imem_req) chk("one_outstanding", 32'(mem_out), 32'd0);

      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (inject > 0) begin
         imem_rvalid = 1'b1;
         inject--;
      end else if (mem_out && cyc == due) begin
         imem_rvalid = 1'b1;
         imem_rdata  = word_of(resp_addr);
         mem_out     = 0;
      end

      imem_ack = 1'b0;
      if (imem_req) begin
         if (ack_wait >= ack_delay) begin
            imem_ack = 1'b1;
            ack_wait = 0;
         end else ack_wait++;
      end else ack_wait = 0;

      if (prev_hold) begin
         chk("req_held", 32'(imem_req), 32'd1);
         chk("addr_held", imem_addr, prev_addr);
      end
      if (prev_branch) chk("flush_valid", 32'(instr_valid), 32'd0);
      if (!instr_valid) chk("nop_when_empty", instruction, NOP);

      ack_seen = 0;
      if (imem_req && imem_ack) begin
         chk("fetch_addr", imem_addr, exp_pc);
         exp_q.push_back(exp_pc);
         exp_pc    = exp_pc + 32'd4;
         mem_out   = 1;
         due       = cyc + lat;
         resp_addr = imem_addr;
         ack_seen  = 1;
      end

      if (instr_valid && !stall && !branch_taken) begin
         if (exp_q.size() == 0) fail_now("spurious_instr");
         else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e);
            chk("instruction", instruction, word_of(e));
            got_pcs.push_back(e);
         end
      end

      if (branch_taken) begin
         exp_q.delete();
         exp_pc = (branch_pc + branch_offset) & 32'hFFFF_FFFC;
      end

      prev_hold   = imem_req && !imem_ack && !branch_taken;
      prev_addr   = imem_addr;
      prev_branch = branch_taken;
      @(negedge clk);
      cyc++;
   endtask

   vec_t tbl[8];

   initial begin
      int n;
      branch_pc     = '0;
      branch_offset = '0;
      imem_rdata    = '0;

      // Reset release with zero-wait memory, cycle by cycle
      tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP};
      tbl[1] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
      tbl[2] = '{1'b0, 1'b0, 32'h4, 1'b0, 32'h0, NOP};
      tbl[3] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h0, word_of(32'h0)};
      tbl[4] = '{1'b0, 1'b0, 32'h8, 1'b0, 32'h0, NOP};
      tbl[5] = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h4, word_of(32'h4)};
      tbl[6] = '{1'b0, 1'b0, 32'hC, 1'b0, 32'h4, NOP};
      tbl[7] = '{1'b0, 1'b1, 32'hC, 1'b1, 32'h8, word_of(32'h8)};

      ack_delay = 0; lat = 1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         stall = tbl[i].stall;
         chk($sformatf("v%0d_req", i),   32'(imem_req),    32'(tbl[i].req));
         chk($sformatf("v%0d_addr", i),  imem_addr,        tbl[i].addr);
         chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
         chk($sformatf("v%0d_pc", i),    instr_pc,         tbl[i].pc);
         chk($sformatf("v%0d_instr", i), instruction,      tbl[i].instr);
         cycle();
      end

      // Stall from reset: queue fills, request drops, then drains in order
      do_reset();
      stall = 1'b1;
      repeat (10) cycle();
      chk("full_req_low", 32'(imem_req), 32'd0);
      chk("full_valid", 32'(instr_valid), 32'd1);
      chk("full_pc", instr_pc, 32'h0);
      stall = 1'b0;
      repeat (12) cycle();
      chk("drain_count", 32'(got_pcs.size() >= 3), 32'd1);
      for (int i = 0; i < 3; i++)
         if (got_pcs.size() > i) chk($sformatf("drain_pc%0d", i), got_pcs[i], 32'(i * 4));

      // Redirect while a response is in flight
      ack_delay = 0; lat = 3;
      do_reset();
      n = 0;
      while (!ack_seen && n < 20) begin cycle(); n++; end
      if (!ack_seen) fail_now("timeout_first_ack");
      branch_taken = 1'b1; branch_pc = 32'h10; branch_offset = 32'hFFFF_FFF8;
      cycle();
      branch_taken = 1'b0;
      got_pcs.delete();
      n = 0;
      while (got_pcs.size() == 0 && n < 30) begin cycle(); n++; end
      if (got_pcs.size() == 0) fail_now("timeout_after_redirect");
      else chk("redirect_first_pc", got_pcs[0], 32'h8);

      // Redirect coinciding with a response while stalled and queue non-empty
      ack_delay = 0; lat = 1;
      do_reset();
      stall = 1'b1;
      n = 0;
      while (!(mem_out && due == cyc && instr_valid) && n < 20) begin cycle(); n++; end
      if (n >= 20) fail_now("timeout_coincide");
      branch_taken = 1'b1; branch_pc = 32'h100; branch_offset = 32'h22;
      cycle();
      branch_taken = 1'b0;
      cycle();
      stall = 1'b0;
      got_pcs.delete();
      n = 0;
      while (got_pcs.size() == 0 && n < 30) begin cycle(); n++; end
      if (got_pcs.size() == 0) fail_now("timeout_after_coincide");
      else chk("coincide_first_pc", got_pcs[0], 32'h120);

      // Slow memory with random stalls and one mid-run redirect
      ack_delay = 2; lat = 3;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         stall        = ($urandom_range(0, 3) == 0);
         branch_taken = (i == 37);
         branch_pc    = 32'h200;
         branch_offset = 32'h41;
         cycle();
      end
      branch_taken = 1'b0;
      stall = 1'b0;
      chk("slow_progress", 32'(got_pcs.size() > 4), 32'd1);

      // Reset asserted while waiting for a response; stale rvalid around it
      ack_delay = 0; lat = 3;
      do_reset();
      repeat (14) cycle();
      n = 0;
      while (!ack_seen && n < 20) begin cycle(); n++; end
      if (!ack_seen) fail_now("timeout_reset_ack");
      chk("pre_reset_pc_nonzero", 32'(instr_pc != 32'h0), 32'd1);
      rst_n = 1'b0;
      imem_ack = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instruction, NOP);
      chk("rst_pc", instr_pc, 32'h0);
      @(negedge clk);
      chk("rst_hold_valid", 32'(instr_valid), 32'd0);
      chk("rst_hold_addr", imem_addr, RESET_PC);
      bench_clear();
      rst_n  = 1'b1;
      inject = 2;
      repeat (20) cycle();
      if (got_pcs.size() == 0) fail_now("timeout_after_reset");
      else chk("post_reset_first_pc", got_pcs[0], RESET_PC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

endmodule
